seq_arbiter: RTL

- Controller that shares one 4-state pulse-sequence engine (inputs x, clk, rst; output y) among N requesters.
- Picks a requester by round-robin and drives the engine's active-low step input through one full pass a->b->c->d->a.
- Checks the engine's y output against the expected pattern at every step and signals completion to the owner.
- Sits between the requester blocks and the engine, sharing the engine's clk and rst.

---
 rtl/seq_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 34 +++
 rtl/seq_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_arb_pkg.sv
// Shared types for the sequence-engine arbiter:
// controller state encoding and expected engine output per state.
package seq_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM1 = 3'd1,
    S_ARM2 = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Engine y seen while the controller sits in state s
  function automatic logic exp_y(input state_t s);
    logic v;
    v = 1'b1;
    case (s)
      S_ARM1:  v = 1'b1;
      S_ARM2:  v = 1'b0;
      S_RUN:   v = 1'b0;
      S_FIN:   v = 1'b1;
      default: v = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request
// searching circularly from ptr+1.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_masked,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx
);

  always_comb begin
    int            w_k;
    logic [PW-1:0] w_idx;
    logic          w_found;
    win     = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_k = int'(ptr) + i;
      if (w_k >= N) w_k = w_k - N;
      w_idx = w_k[PW-1:0];
      if (!w_found && req_masked[w_idx]) begin
        w_found    = 1'b1;
        win[w_idx] = 1'b1;
        win_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin owner of a shared 4-state pulse-sequence engine:
// steps it through a->b->c->d->a per job and checks y each step.
module seq_arbiter
  import seq_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic         eng_x,
  input  logic         eng_y,
  output logic         busy,
  output logic         err
);

  localparam int PW = $clog2(N);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_done;
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_req_m;
  logic [N-1:0]  w_win;
  logic [PW-1:0] w_win_idx;
  logic          w_y_ok;

  // The served requester is masked during its done cycle
  assign w_req_m = req & ~r_done;
  assign w_y_ok  = (eng_y == exp_y(r_state));

  rr_pick #(.N(N)) u_pick (
    .req_masked (w_req_m),
    .ptr        (r_ptr),
    .win        (w_win),
    .win_idx    (w_win_idx)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!eng_y)        w_next = S_ERR;
        else if (|w_req_m) w_next = S_ARM1;
        else               w_next = S_IDLE;
      end
      S_ARM1:  w_next = w_y_ok ? S_ARM2 : S_ERR;
      S_ARM2:  w_next = w_y_ok ? S_RUN  : S_ERR;
      S_RUN:   w_next = w_y_ok ? S_FIN  : S_ERR;
      S_FIN:   w_next = w_y_ok ? S_IDLE : S_ERR;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_comb begin
    eng_x = 1'b1;
    busy  = 1'b0;
    err   = 1'b0;
    unique case (r_state)
      S_ARM1, S_ARM2: begin
        eng_x = 1'b0;
        busy  = 1'b1;
      end
      S_RUN, S_FIN: busy = 1'b1;
      S_ERR:        err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt  <= '0;
      r_done <= '0;
      r_ptr  <= PW'(N - 1);
    end else begin
      r_done <= '0;
      if (r_state == S_IDLE && w_next == S_ARM1) begin
        r_gnt <= w_win;
        r_ptr <= w_win_idx;
      end
      if (r_state == S_FIN && w_next == S_IDLE) begin
        r_done <= r_gnt;
        r_gnt  <= '0;
      end
      if (w_next == S_ERR) r_gnt <= '0;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;

endmodule
